// File: rtl/mul_hilo_unit_pkg.sv
// Shared definitions for the ALU-control multiply protocol: function codes and multiplier FSM states.
package mul_hilo_unit_pkg;

  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_MUL     = 6'b011001;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_HILO_WR = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_hilo_unit_hilo_reg.sv
// HI/LO product registers with commit strobe, valid flag and registered MFHI/MFLO read mux.
module mul_hilo_unit_hilo_reg
  import mul_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [2*WIDTH-1:0] wr_data,
  input  logic [5:0]         rd_code,
  output logic [WIDTH-1:0]   rd_data,
  output logic               hilo_valid
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             valid_q, valid_d;

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    valid_d = valid_q;
    if (wr_en) begin
      hi_d    = wr_data[2*WIDTH-1:WIDTH];
      lo_d    = wr_data[WIDTH-1:0];
      valid_d = 1'b1;
    end
    // Read mux looks at the current registers, so a read on the commit edge sees the old value.
    case (rd_code)
      FN_MFHI: rd_d = hi_q;
      FN_MFLO: rd_d = lo_q;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= '0;
      lo_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
    end
  end

  assign rd_data    = rd_q;
  assign hilo_valid = valid_q;

endmodule

// File: rtl/mul_hilo_unit.sv
// Multiply responder: shift-add multiplier FSM committing into HI/LO.
// Define MUL_SIGNED_EN for two's-complement operands (one extra negation cycle).
module mul_hilo_unit
  import mul_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done,
  output logic             hilo_valid
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pending_q, pending_d;
  logic               enter_done;
  logic               hilo_wr;
  logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MUL_SIGNED_EN
  logic               neg_q, neg_d;

  // Magnitude of the most-negative value still fits as a WIDTH-bit unsigned.
  assign a_mag = dataA[WIDTH-1] ? (~dataA + 1'b1) : dataA;
  assign b_mag = dataB[WIDTH-1] ? (~dataB + 1'b1) : dataB;
`else
  assign a_mag = dataA;
  assign b_mag = dataB;
`endif

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    product_d  = product_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pending_d  = pending_q;
    enter_done = 1'b0;
    hilo_wr    = 1'b0;
`ifdef MUL_SIGNED_EN
    neg_d      = neg_q;
`endif

    case (state_q)
      IDLE: begin
        if (Signal == FN_MUL) begin
          state_d   = RUN;
          mcand_d   = {{WIDTH{1'b0}}, a_mag};
          mplier_d  = b_mag;
          product_d = '0;
          counter_d = '0;
          busy_d    = 1'b1;
`ifdef MUL_SIGNED_EN
          neg_d     = dataA[WIDTH-1] ^ dataB[WIDTH-1];
`endif
        end
      end

      RUN: begin
`ifdef MUL_SIGNED_EN
        if (counter_q == CNT_W'(WIDTH)) begin
          if (neg_q) product_d = ~product_q + 1'b1;
          enter_done = 1'b1;
        end else begin
`else
        begin
`endif
          if (mplier_q[0]) product_d = product_q + mcand_q;
          mcand_d   = mcand_q << 1;
          mplier_d  = mplier_q >> 1;
          counter_d = (counter_q == '1) ? counter_q : counter_q + 1'b1;
`ifndef MUL_SIGNED_EN
          if (counter_q == CNT_W'(WIDTH - 1)) enter_done = 1'b1;
`endif
        end

        if (enter_done) begin
          busy_d = 1'b0;
          if (pending_q || (Signal == FN_HILO_WR)) begin
            hilo_wr   = 1'b1;
            pending_d = 1'b0;
            state_d   = IDLE;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else if (Signal == FN_HILO_WR) begin
          pending_d = 1'b1;
        end
      end

      DONE: begin
        if (Signal == FN_HILO_WR) begin
          hilo_wr = 1'b1;
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      counter_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
`ifdef MUL_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pending_q <= pending_d;
`ifdef MUL_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  mul_hilo_unit_hilo_reg #(.WIDTH(WIDTH)) u_hilo_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (hilo_wr),
    .wr_data   (product_d),
    .rd_code   (Signal),
    .rd_data   (dataOut),
    .hilo_valid(hilo_valid)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Self-checking bench for mul_hilo_unit against an arithmetic model of the multiply protocol.
module tb_mul_hilo_unit;
  import mul_hilo_unit_pkg::*;

  localparam int unsigned W = 32;
`ifdef MUL_SIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   Signal;
  logic [W-1:0] dataA, dataB, dataOut;
  logic         busy, done, hilo_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mul_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Signal    (Signal),
    .dataA     (dataA),
    .dataB     (dataB),
    .dataOut   (dataOut),
    .busy      (busy),
    .done      (done),
    .hilo_valid(hilo_valid)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_SIGNED_EN
    logic signed [63:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
`else
    logic [63:0] ua, ub;
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    return ua * ub;
`endif
  endfunction

  task automatic start_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    Signal = FN_MUL;
    dataA  = a;
    dataB  = b;
    tick;
    dataA = $urandom;
    dataB = $urandom;
  endtask

  task automatic read_check(input string tag);
    Signal = FN_MFHI;
    tick;
    check_eq({tag, " HI"}, 64'(dataOut), 64'(m_hi));
    Signal = FN_MFLO;
    tick;
    check_eq({tag, " LO"}, 64'(dataOut), 64'(m_lo));
    Signal = FN_ADD;
    tick;
    check_eq({tag, " other code reads 0"}, 64'(dataOut), 64'd0);
  endtask

  // MUL held throughout the run, HILO_WR issued once done is seen.
  task automatic mul_full(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int cyc;
    logic [63:0] p;
    p = ref_prod(a, b);
    start_mul(a, b);
    cyc = 0;
    while (busy && cyc < 200) begin
      tick;
      cyc++;
    end
    check_eq({tag, " latency"}, 64'(cyc), 64'(LAT));
    check_eq({tag, " done"}, 64'(done), 64'd1);
    Signal = FN_HILO_WR;
    tick;
    check_eq({tag, " done cleared"}, 64'(done), 64'd0);
    check_eq({tag, " hilo_valid"}, 64'(hilo_valid), 64'd1);
    m_hi = p[63:32];
    m_lo = p[31:0];
    read_check(tag);
  endtask

  // HILO_WR issued at run cycle k; reads MFLO afterwards to see the commit-edge behaviour.
  task automatic mul_pending(input logic [W-1:0] a, input logic [W-1:0] b, input int k, input string tag);
    int cyc;
    bit saw_done;
    logic [63:0] p;
    logic [W-1:0] old_lo;
    p = ref_prod(a, b);
    old_lo = m_lo;
    start_mul(a, b);
    cyc = 0;
    saw_done = 1'b0;
    while (busy && cyc < 200) begin
      if (cyc == k) Signal = FN_HILO_WR;
      else if (cyc > k) Signal = FN_MFLO;
      else Signal = FN_MUL;
      tick;
      cyc++;
      if (done) saw_done = 1'b1;
    end
    check_eq({tag, " latency"}, 64'(cyc), 64'(LAT));
    check_eq({tag, " done never pulses"}, 64'(saw_done), 64'd0);
    check_eq({tag, " hilo_valid"}, 64'(hilo_valid), 64'd1);
    if (k < LAT - 1)
      check_eq({tag, " commit-edge read old LO"}, 64'(dataOut), 64'(old_lo));
    Signal = FN_MFLO;
    tick;
    check_eq({tag, " done after commit"}, 64'(done), 64'd0);
    m_hi = p[63:32];
    m_lo = p[31:0];
    check_eq({tag, " new LO next cycle"}, 64'(dataOut), 64'(m_lo));
    read_check(tag);
  endtask

  initial begin
    rst_n  = 1'b0;
    Signal = '0;
    dataA  = '0;
    dataB  = '0;
    m_hi   = '0;
    m_lo   = '0;
    #12;
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset done", 64'(done), 64'd0);
    check_eq("reset hilo_valid", 64'(hilo_valid), 64'd0);
    check_eq("reset dataOut", 64'(dataOut), 64'd0);
    rst_n = 1'b1;
    tick;

    Signal = FN_HILO_WR;
    tick;
    check_eq("idle HILO_WR ignored", 64'(hilo_valid), 64'd0);
    read_check("idle write");

    mul_full(32'd3, 32'd5, "3x5");
    mul_full(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max x max");
    mul_full(32'hFFFF_FFFD, 32'd5, "m3 x 5");
    mul_full(32'h8000_0000, 32'h8000_0000, "msb x msb");
    mul_full(32'h8000_0000, 32'd1, "msb x 1");
    mul_full(32'd0, 32'h1234_5678, "zero x b");

    mul_pending(32'd123, 32'd456, 10, "pending@10");
    mul_pending($urandom, $urandom, LAT - 1, "wr on done entry");

    // Reset partway through a run aborts it and clears HI/LO.
    start_mul(32'hDEAD_BEEF, 32'hCAFE_F00D);
    repeat (16) tick;
    Signal = FN_HILO_WR;
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrun reset busy", 64'(busy), 64'd0);
    check_eq("midrun reset hilo_valid", 64'(hilo_valid), 64'd0);
    check_eq("midrun reset dataOut", 64'(dataOut), 64'd0);
    Signal = FN_ADD;
    tick;
    rst_n = 1'b1;
    tick;
    Signal = FN_HILO_WR;
    tick;
    check_eq("pending cleared by reset", 64'(hilo_valid), 64'd0);
    m_hi = '0;
    m_lo = '0;
    read_check("after reset");
    mul_full(32'd7, 32'd6, "7x6");

    for (int i = 0; i < 6; i++) begin
      mul_full($urandom, $urandom, $sformatf("rand%0d", i));
    end
    mul_pending($urandom, $urandom, $urandom_range(0, LAT - 2), "rand pending");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_hilo_unit.md
Name: mul_hilo_unit

Overview:
- Responder side of the ALU-control multiply protocol.
- Consumes the 6-bit function code driven on the multiplier control line.
- Runs a 32-cycle shift-add 32x32 multiply and commits the 64-bit product to HI/LO when the HiLo-open code (6'b111111) arrives.
- Serves MFHI/MFLO reads to the datapath mux.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH; iteration count = WIDTH.
- CNT_W, 6, width of the iteration counter (must hold WIDTH).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Signal  in  6  function code from ALU control (MUL=011001, MFHI=010000, MFLO=010010, HILO_WR=111111; others ignored).
- dataA  in  WIDTH  multiplicand.
- dataB  in  WIDTH  multiplier.
- dataOut  out  WIDTH  HI when Signal==MFHI, LO when Signal==MFLO, else 0; registered.
- busy  out  1  multiply in progress.
- done  out  1  product valid and not yet committed.
- hilo_valid  out  1  HI/LO hold a committed product.

Behaviour:
- Reset (async, rst_n=0) clears all state:
  - state=IDLE; counter, product, HI, LO, dataOut = 0.
  - busy, done, hilo_valid, pending = 0.
- FSM states:
  - IDLE -> RUN: Signal==MUL in IDLE. Capture dataA into mcand (2*WIDTH, zero-extended) and dataB into mplier. Clear product, counter=0, busy=1.
  - RUN, per cycle:
    - If mplier[0], product += mcand.
    - mcand <<= 1; mplier >>= 1; counter++.
    - After the WIDTH-th iteration (counter==WIDTH-1 at the edge): go to DONE, busy=0, done=1.
    - Result is available exactly WIDTH cycles after the start edge.
  - DONE -> IDLE: on commit.
- Signal==MUL while in RUN/DONE does not restart; held MUL is the normal protocol. A new multiply starts only from IDLE.
- Commit rules:
  - Signal==HILO_WR in DONE: HI=product[2W-1:W], LO=product[W-1:0], hilo_valid=1, done=0, state=IDLE. Same edge.
  - HILO_WR in RUN: set pending=1; commit on the cycle DONE is entered, going straight to IDLE without asserting done.
  - HILO_WR in IDLE with no pending: ignored; HI/LO unchanged.
  - HILO_WR and DONE entry on the same edge: commit that edge.
- Reads:
  - dataOut is registered, 1-cycle latency after MFHI/MFLO is presented.
  - A read on the commit edge returns the old HI/LO; the new value is returned the cycle after.
  - dataOut=0 for any other code.
- Arithmetic:
  - Unsigned; product is exact in 2*WIDTH bits, no overflow.
  - Counter saturates; the RUN exit condition uses equality, no wrap.
- Reset mid-RUN: multiply is aborted and pending is cleared. HI/LO are cleared, not retained.

Optional Feature:
- MUL_SIGNED_EN defined:
  - Operands are two's complement. Magnitudes are multiplied.
  - On entry to DONE, the product is negated if sign(dataA)^sign(dataB); this adds one extra cycle (DONE at WIDTH+1).
  - Most-negative operand handled correctly: its magnitude fits in a WIDTH-bit unsigned.
- MUL_SIGNED_EN undefined: pure unsigned, latency WIDTH, no sign logic.

Decomposition:
- Shared package (also used by ALU control): function code constants AND, OR, ADD, SUB, SLT, SRL, MUL, MFHI, MFLO, HILO_WR=6'b111111; FSM state enum IDLE/RUN/DONE.
- One sub-module: hilo_reg. Holds the 2xWIDTH HI/LO registers, write strobe, hilo_valid, and the registered MFHI/MFLO read mux. The multiplier FSM stays in the top.

Test Plan:
- Hold Signal=MUL with dataA=3, dataB=5 for 32 cycles, then HILO_WR -> busy for 32 cycles, done high; MFHI->0, MFLO->15.
- dataA=dataB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- HILO_WR issued at cycle 10 of RUN -> no write until DONE entry; HI/LO update on that edge; done never pulses.
- Drop rst_n at cycle 16 of RUN -> busy=0, HI=LO=0; a subsequent MUL 7x6 gives LO=42.
- MFLO on the commit edge -> returns previous LO; next cycle returns the new LO.
- MUL_SIGNED_EN: dataA=-3, dataB=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; done at cycle 33.
